atanh_cordic: RTL and testbench

Sequential fixed-point inverse hyperbolic tangent unit. It accepts a signed fixed-point activation value y and returns x = atanh(y) in the same format. It sits downstream of the GRU activation path, where it recovers pre-activation values from tanh outputs for debug readback and gradient checks. It uses a hyperbolic CORDIC in vectoring mode, one micro-rotation per cycle, with valid/ready handshakes on both sides.

---
 rtl/atanh_cordic.sv | 227 ++++++++++++++++++++++
 tb/tb_atanh_cordic.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/atanh_cordic.sv
// atanh_cordic -- sequential fixed-point inverse hyperbolic tangent.
// Hyperbolic CORDIC in vectoring mode, one micro-rotation per cycle.
// Computes x_out = atanh(y_in) in signed Q(INT_WIDTH).(FRAC_WIDTH).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   y_in valid            in_ready   block idle, can accept
//   y_in       signed input value
//   out_valid  x_out valid           out_ready  consumer accepts x_out
//   x_out      signed atanh result   sat        input clamped/saturated
//
// Build option: define ATANH_RANGE_EXT_EN to compile in the two
// expanded-range pre-rotations (PRE state) and widen the unclamped
// input range to |y| < 1.0.
module atanh_cordic #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
  parameter int ITER       = 12,
  parameter int GUARD      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic                    sat
);

  localparam int IW      = WIDTH + GUARD;
  localparam int FW      = FRAC_WIDTH + GUARD;
  localparam int N_STEPS = (ITER >= 13) ? ITER + 2 : ITER + 1;
  localparam int CW      = $clog2(N_STEPS + 1);
`ifdef ATANH_RANGE_EXT_EN
  localparam int Y_LIM   = (1 << FRAC_WIDTH) - 1;
`else
  localparam int Y_LIM   = (205 << FRAC_WIDTH) / 256;
`endif

  localparam logic signed [IW-1:0]    X_ONE  = IW'(1 << FW);
  localparam logic signed [IW-1:0]    Z_SAT  = IW'(3 << FW);
  localparam logic signed [IW-1:0]    RND    = IW'(1 << (GUARD - 1));
  localparam logic        [WIDTH:0]   ONE_M  = (WIDTH+1)'(1 << FRAC_WIDTH);
  localparam logic        [WIDTH:0]   YLIM_M = (WIDTH+1)'(Y_LIM);
  localparam logic signed [WIDTH-1:0] YLIM_W = WIDTH'(Y_LIM);

  // Angle constants are held at 20 fractional bits and rounded to FW.
  function automatic logic signed [IW-1:0] q20_to_fw(input int v);
    return IW'(((v >>> (19 - FW)) + 1) >>> 1);
  endfunction

  function automatic int atanh_q20(input int unsigned s);
    case (s)
      1:       return 575989;
      2:       return 267820;
      3:       return 131761;
      4:       return 65622;
      5:       return 32779;
      6:       return 16385;
      7:       return 8192;
      default: return (s <= 20) ? (1 << (20 - s)) : 0;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [IW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [WIDTH-1:0] x_out_q, x_out_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;

  // Micro-rotation datapath
  int unsigned             cnt_i, sh;
  logic signed [IW-1:0]    xs, ys, ang, x_rot, y_rot, z_rot;

  always_comb begin
    cnt_i = 32'(cnt_q);
    // Shift schedule 1,2,3,4,4,5,...,13,13,14,...: index 4 (and 13) repeated
    if (cnt_i < 4)        sh = cnt_i + 1;
    else if (cnt_i <= 13) sh = cnt_i;
    else                  sh = cnt_i - 1;
    xs  = x_q >>> sh;
    ys  = y_q >>> sh;
    ang = q20_to_fw(atanh_q20(sh));
`ifdef ATANH_RANGE_EXT_EN
    // Expanded-range steps i=-1 then i=0: factor 1 - 2^(i-2)
    if (state_q == S_PRE) begin
      sh  = (cnt_q == '0) ? 3 : 2;
      xs  = x_q - (x_q >>> sh);
      ys  = y_q - (y_q >>> sh);
      ang = (cnt_q == '0) ? q20_to_fw(1419798) : q20_to_fw(1020217);
    end
`endif
    if (!y_q[IW-1]) begin
      x_rot = x_q - ys;
      y_rot = y_q - xs;
      z_rot = z_q + ang;
    end else begin
      x_rot = x_q + ys;
      y_rot = y_q + xs;
      z_rot = z_q - ang;
    end
  end

  // Input range classification
  logic                    neg;
  logic signed [WIDTH:0]   yext;
  logic        [WIDTH:0]   mag;
  logic signed [WIDTH-1:0] ysel;

  always_comb begin
    neg  = y_in[WIDTH-1];
    yext = {y_in[WIDTH-1], y_in};
    mag  = neg ? -yext : yext;
    ysel = neg ? -YLIM_W : YLIM_W;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    x_out_d     = x_out_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d   = X_ONE;
          y_d   = {y_in, {GUARD{1'b0}}};
          z_d   = '0;
          cnt_d = '0;
          sat_d = 1'b0;
          if (mag >= ONE_M) begin
            // Park the clamped result in Z and jump to the final rounding
            // cycle so the result appears one cycle after acceptance.
            sat_d   = 1'b1;
            z_d     = neg ? -Z_SAT : Z_SAT;
            cnt_d   = CW'(N_STEPS);
            state_d = S_ITER;
          end else begin
            if (mag > YLIM_M) begin
              sat_d = 1'b1;
              y_d   = {ysel, {GUARD{1'b0}}};
            end
`ifdef ATANH_RANGE_EXT_EN
            state_d = S_PRE;
`else
            state_d = S_ITER;
`endif
          end
        end
      end
`ifdef ATANH_RANGE_EXT_EN
      S_PRE: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_ITER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_ITER: begin
        if (cnt_q == CW'(N_STEPS)) begin
          x_out_d     = WIDTH'((z_q + RND) >>> GUARD);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          x_d   = x_rot;
          y_d   = y_rot;
          z_d   = z_rot;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      x_out_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      x_out_q     <= x_out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_atanh_cordic.sv
// Self-checking bench for atanh_cordic: directed cases plus randomized
// inputs compared against a real-arithmetic atanh reference.
module tb_atanh_cordic;

  localparam int WIDTH = 17;
`ifdef ATANH_RANGE_EXT_EN
  localparam int LAT   = 16;
  localparam int YLIM  = 255;
  localparam int RMAX  = 230;
`else
  localparam int LAT   = 14;
  localparam int YLIM  = 205;
  localparam int RMAX  = 240;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [WIDTH-1:0] y_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [WIDTH-1:0] x_out;
  logic                    sat;

  int n_checks = 0;
  int n_pass   = 0;

  atanh_cordic #(.INT_WIDTH(8), .FRAC_WIDTH(8), .ITER(12), .GUARD(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  // Reference: clamp per range rules, then atanh in real arithmetic, Q8 round.
  function automatic int ref_atanh(input int y, output bit s);
    int  yy;
    real v, r;
    s = 1'b0;
    if (y >= 256 || y <= -256) begin
      s = 1'b1;
      return (y < 0) ? -768 : 768;
    end
    yy = y;
    if (y > YLIM)  begin yy = YLIM;  s = 1'b1; end
    if (y < -YLIM) begin yy = -YLIM; s = 1'b1; end
    v = real'(yy) / 256.0;
    r = 0.5 * $ln((1.0 + v) / (1.0 - v)) * 256.0;
    return int'($floor(r + 0.5));
  endfunction

  // Drive one transaction, measure latency, optionally stall out_ready.
  task automatic run_one(input string tag, input int y, input int hold,
                         output int xo, output bit so, output int lat);
    int n;
    bit busy_ready;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_rdy"}, int'(in_ready), 1);
    y_in = WIDTH'(y);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_busy"}, int'(busy_ready), 0);
    xo = int'(x_out);
    so = sat;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_v"}, int'(out_valid), 1);
      check({tag, "_hold_x"}, int'(x_out), xo);
      check({tag, "_hold_s"}, int'(sat), int'(so));
      check({tag, "_hold_r"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ack_v"}, int'(out_valid), 0);
    check({tag, "_ack_r"}, int'(in_ready), 1);
  endtask

  initial begin
    int  xo, lat, y, er;
    bit  so, es;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_xout", int'(x_out), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_ready", int'(in_ready), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", int'(in_ready), 1);

    // Zero input
    run_one("zero", 0, 0, xo, so, lat);
    check("zero_x", xo, 0);
    check("zero_sat", int'(so), 0);
    check("zero_lat", lat, LAT);

    // Mid-range values
    run_one("p128", 128, 0, xo, so, lat);
    check("p128_x", xo, 141, 1);
    check("p128_sat", int'(so), 0);
    check("p128_lat", lat, LAT);
    run_one("m192", -192, 0, xo, so, lat);
    check("m192_x", xo, -249, 1);
    check("m192_sat", int'(so), 0);

    // Near-unity value: clamped without range extension
    run_one("p243", 243, 0, xo, so, lat);
`ifdef ATANH_RANGE_EXT_EN
    check("p243_x", xo, 467, 2);
    check("p243_sat", int'(so), 0);
`else
    check("p243_x", xo, 282, 1);
    check("p243_sat", int'(so), 1);
`endif

    // |y| >= 1.0 saturation, one-cycle result
    run_one("p256", 256, 0, xo, so, lat);
    check("p256_x", xo, 768);
    check("p256_sat", int'(so), 1);
    check("p256_lat", lat, 1);
    run_one("m512", -512, 0, xo, so, lat);
    check("m512_x", xo, -768);
    check("m512_sat", int'(so), 1);
    check("m512_lat", lat, 1);

    // Output stall for 5 cycles
    run_one("hold", -192, 5, xo, so, lat);
    check("hold_x", xo, -249, 1);

    // Reset during iteration; x_out currently holds a nonzero result
    y_in = WIDTH'(100);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_xout", int'(x_out), 0);
    check("mid_rst_sat", int'(sat), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    run_one("post_rst", 128, 0, xo, so, lat);
    check("post_rst_x", xo, 141, 1);
    check("post_rst_lat", lat, LAT);

    // Randomized inputs against the reference
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        y = int'($urandom_range(256, 3000));
        if ($urandom_range(0, 1) == 1) y = -y;
      end else begin
        y = int'($urandom_range(0, 2 * RMAX)) - RMAX;
      end
      er = ref_atanh(y, es);
      run_one($sformatf("rnd%0d", i), y, int'($urandom_range(0, 2)), xo, so, lat);
      check($sformatf("rnd%0d_x(y=%0d)", i, y), xo, er, 2);
      check($sformatf("rnd%0d_sat", i), int'(so), int'(es));
      check($sformatf("rnd%0d_lat", i), lat, (y >= 256 || y <= -256) ? 1 : LAT);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
